// File: rtl/psum_accum_cmp_if.sv
// Beat/result bus for psum_accum_cmp: lane-packed psum beats in, binarised results out.
interface psum_accum_cmp_if #(
  parameter int unsigned NUM_LANES  = 256,
  parameter int unsigned LANE_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [NUM_LANES*LANE_WIDTH-1:0] psum_in;
  logic [ADDR_WIDTH-1:0]           address_in;
  logic                            i_valid;
  logic                            i_last;
  logic                            o_data;
  logic [ADDR_WIDTH-1:0]           address_out;
  logic                            o_valid;
  logic                            o_ovf;

  modport master (
    output psum_in, address_in, i_valid, i_last,
    input  o_data, address_out, o_valid, o_ovf
  );

  modport slave (
    input  psum_in, address_in, i_valid, i_last,
    output o_data, address_out, o_valid, o_ovf
  );
endinterface

// File: rtl/psum_accum_cmp.sv
// Reduces psum lanes through a registered adder tree, accumulates beats of one output
// pixel and binarises the saturated total against a kernel/channel-derived threshold.
module psum_accum_cmp #(
  parameter int unsigned NUM_LANES  = 256,
  parameter int unsigned LANE_WIDTH = 5,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          in_channel,
  input  logic [4:0]           kernel_size,
  input  logic                 cmp_mode,
  psum_accum_cmp_if.slave      bus
);

  localparam int unsigned L      = $clog2(NUM_LANES);
  localparam int unsigned SUM_W  = LANE_WIDTH + L;
  localparam int unsigned ACC_XW = ACC_WIDTH + 1;
  localparam int unsigned THR_W  = 17;
  localparam int unsigned CMP_W  = (ACC_WIDTH > THR_W) ? ACC_WIDTH : THR_W;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  // tree[k] holds NUM_LANES>>k partial sums; stored at the final width so no stage truncates.
  logic [SUM_W-1:0]      tree [0:L][0:NUM_LANES-1];
  logic                  vld  [0:L];
  logic                  lst  [0:L];
  logic [ADDR_WIDTH-1:0] adr  [0:L];

  logic [ACC_WIDTH-1:0]  acc;
  logic                  data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  valid_q;
  logic                  ovf_q;

  logic [2:0]            kernel_num_c;
  logic [THR_W-1:0]      thr_c;
  logic [ACC_XW-1:0]     raw_c;
  logic [ACC_WIDTH-1:0]  sat_c;
  logic                  hit_c;

  // Input capture and pairwise reduction pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= int'(L); k++) begin
        vld[k] <= 1'b0;
        lst[k] <= 1'b0;
        adr[k] <= '0;
        for (int j = 0; j < int'(NUM_LANES); j++) tree[k][j] <= '0;
      end
    end else begin
      vld[0] <= bus.i_valid;
      lst[0] <= bus.i_last;
      if (bus.i_valid) begin
        adr[0] <= bus.address_in;
        for (int j = 0; j < int'(NUM_LANES); j++)
          tree[0][j] <= SUM_W'(bus.psum_in[j*LANE_WIDTH +: LANE_WIDTH]);
      end
      for (int k = 1; k <= int'(L); k++) begin
        vld[k] <= vld[k-1];
        lst[k] <= lst[k-1];
        adr[k] <= adr[k-1];
        for (int j = 0; j < int'(NUM_LANES / 2); j++)
          if (j < int'(NUM_LANES >> k)) tree[k][j] <= tree[k-1][2*j] + tree[k-1][2*j+1];
      end
    end
  end

  // Non-one-hot kernel codes fall back to a 1x1 kernel.
  always_comb begin
    kernel_num_c = 3'd1;
    case (kernel_size)
      5'b10000: kernel_num_c = 3'd5;
      5'b01000: kernel_num_c = 3'd4;
      5'b00100: kernel_num_c = 3'd3;
      5'b00010: kernel_num_c = 3'd2;
      default:  kernel_num_c = 3'd1;
    endcase
  end

  always_comb begin
    thr_c = (THR_W'(kernel_num_c) * THR_W'(kernel_num_c) * THR_W'(in_channel)) >> 1;
    raw_c = {1'b0, acc} + ACC_XW'(tree[L][0]);
    sat_c = raw_c[ACC_WIDTH] ? ACC_MAX : raw_c[ACC_WIDTH-1:0];
    hit_c = cmp_mode ? (CMP_W'(sat_c) >  CMP_W'(thr_c))
                     : (CMP_W'(sat_c) >= CMP_W'(thr_c));
  end

  // Accumulate non-final beats; on the final beat emit the compare result and restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      data_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (vld[L]) begin
        if (raw_c[ACC_WIDTH]) ovf_q <= 1'b1;
        if (lst[L]) begin
          data_q  <= hit_c;
          addr_q  <= adr[L];
          valid_q <= 1'b1;
          acc     <= '0;
        end else begin
          acc <= sat_c;
        end
      end
    end
  end

  assign bus.o_data      = data_q;
  assign bus.address_out = addr_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_ovf       = ovf_q;

endmodule

// File: tb/tb_psum_accum_cmp.sv
// Randomised and directed bench for psum_accum_cmp against a beat-level arithmetic model;
// a second instance with a 13-bit accumulator exercises saturation.
module tb_psum_accum_cmp;

  localparam int unsigned NL    = 256;
  localparam int unsigned LW    = 5;
  localparam int unsigned AW    = 12;
  localparam int unsigned LAT   = 10;
  localparam int unsigned PW    = NL * LW;
  localparam int unsigned A_MAX = (1 << 20) - 1;
  localparam int unsigned B_MAX = (1 << 13) - 1;

  typedef struct packed {
    logic [31:0]   due;
    logic          data;
    logic [AW-1:0] addr;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   in_channel;
  logic [4:0]    kernel_size;
  logic          cmp_mode;
  logic [PW-1:0] psum;
  logic [AW-1:0] addr;
  logic          valid;
  logic          last;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int unsigned m_acc_a, m_acc_b;
  bit          m_ovf_a, m_ovf_b;
  res_t        exp_a[$], exp_b[$], got_a[$], got_b[$];

  psum_accum_cmp_if #(.NUM_LANES(NL), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) bus_a ();
  psum_accum_cmp_if #(.NUM_LANES(NL), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) bus_b ();

  psum_accum_cmp #(.NUM_LANES(NL), .LANE_WIDTH(LW), .ACC_WIDTH(20), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_channel(in_channel), .kernel_size(kernel_size),
    .cmp_mode(cmp_mode), .bus(bus_a)
  );

  psum_accum_cmp #(.NUM_LANES(NL), .LANE_WIDTH(LW), .ACC_WIDTH(13), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_channel(in_channel), .kernel_size(kernel_size),
    .cmp_mode(cmp_mode), .bus(bus_b)
  );

  assign bus_a.psum_in = psum;  assign bus_b.psum_in = psum;
  assign bus_a.address_in = addr;  assign bus_b.address_in = addr;
  assign bus_a.i_valid = valid;  assign bus_b.i_valid = valid;
  assign bus_a.i_last = last;  assign bus_b.i_last = last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every result with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus_a.o_valid)
      got_a.push_back(res_t'{due: cyc, data: bus_a.o_data, addr: bus_a.address_out, ovf: bus_a.o_ovf});
    if (bus_b.o_valid)
      got_b.push_back(res_t'{due: cyc, data: bus_b.o_data, addr: bus_b.address_out, ovf: bus_b.o_ovf});
  end

  function automatic int unsigned kern_num(input logic [4:0] k);
    case (k)
      5'b10000: return 5;
      5'b01000: return 4;
      5'b00100: return 3;
      5'b00010: return 2;
      default:  return 1;
    endcase
  endfunction

  function automatic bit expect_bit(input int unsigned total);
    int unsigned thr;
    thr = (kern_num(kernel_size) * kern_num(kernel_size) * 32'(in_channel)) / 2;
    return cmp_mode ? (total > thr) : (total >= thr);
  endfunction

  function automatic logic [PW-1:0] fill(input int unsigned v, input int unsigned n);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(n); i++) p[i*LW +: LW] = LW'(v);
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_psum(input int unsigned maxv);
    logic [PW-1:0] p;
    for (int i = 0; i < int'(NL); i++) p[i*LW +: LW] = LW'($urandom_range(maxv, 0));
    return p;
  endfunction

  // Present one beat and advance the model: lane sum, saturating accumulate, result on last.
  task automatic send(input logic [PW-1:0] p, input logic [AW-1:0] a, input bit l);
    int unsigned s, ta, tb2;
    @(negedge clk);
    psum = p; addr = a; valid = 1'b1; last = l;
    s = 0;
    for (int i = 0; i < int'(NL); i++) s += 32'(p[i*LW +: LW]);
    ta  = m_acc_a + s;
    tb2 = m_acc_b + s;
    if (ta > A_MAX)  begin ta  = A_MAX; m_ovf_a = 1'b1; end
    if (tb2 > B_MAX) begin tb2 = B_MAX; m_ovf_b = 1'b1; end
    if (l) begin
      exp_a.push_back(res_t'{due: cyc + LAT, data: expect_bit(ta),  addr: a, ovf: m_ovf_a});
      exp_b.push_back(res_t'{due: cyc + LAT, data: expect_bit(tb2), addr: a, ovf: m_ovf_b});
      m_acc_a = 0; m_acc_b = 0;
    end else begin
      m_acc_a = ta; m_acc_b = tb2;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; last = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    valid = 1'b0; last = 1'b0;
    m_acc_a = 0; m_acc_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    exp_a.delete(); exp_b.delete();
    repeat (2) @(negedge clk);
    got_a.delete(); got_b.delete();
    rst_n = 1'b1;
  endtask

  task automatic drop_b();
    exp_b.delete(); got_b.delete();
  endtask

  task automatic test_reset();
    valid = 1'b1; last = 1'b1; psum = rand_psum(31); addr = 12'hFFF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b required 0", bus_a.o_valid); end
    n_checks++; if (bus_a.o_data !== 1'b0) begin n_fail++; $display("FAIL reset_o_data: got %b required 0", bus_a.o_data); end
    n_checks++; if (bus_a.address_out !== '0) begin n_fail++; $display("FAIL reset_address_out: got %h required 0", bus_a.address_out); end
    n_checks++; if (bus_a.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_o_ovf: got %b required 0", bus_a.o_ovf); end
    n_checks++; if (bus_b.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_o_ovf_b: got %b required 0", bus_b.o_ovf); end
    valid = 1'b0; last = 1'b0;
    rst_n = 1'b1;
    idle(LAT + 2);
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL reset_quiet: got %0d results required 0", got_a.size()); end
    got_a.delete(); drop_b();
  endtask

  task automatic test_single_beat();
    res_t e, g;
    kernel_size = 5'b00100; in_channel = 12'd64; cmp_mode = 1'b0;
    send(fill(1, NL), 12'hA5C, 1'b1);
    idle(LAT + 3);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL single_beat: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL single_beat: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL single_beat_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    drop_b();
  endtask

  task automatic test_two_beat();
    res_t e, g;
    kernel_size = 5'b00100; in_channel = 12'd64;
    for (int m = 0; m < 2; m++) begin
      cmp_mode = 1'(m);
      send(fill(1, NL), 12'(10 + 2*m), 1'b0);
      send(fill(1, 32), 12'(11 + 2*m), 1'b1);
      idle(LAT + 2);
    end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL two_beat: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL two_beat: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL two_beat_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    drop_b();
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    e = '0;
    kernel_size = 5'b00001; in_channel = 12'd1; cmp_mode = 1'b1;
    for (int i = 0; i < 4; i++) send(fill((i % 2 == 0) ? 0 : 31, NL), 12'(i), 1'b1);
    idle(LAT + 3);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL back_to_back: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL back_to_back: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL back_to_back_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    n_checks++;
    if (bus_a.o_data !== e.data || bus_a.address_out !== e.addr) begin
      n_fail++; $display("FAIL output_hold: got data=%b addr=%h required data=%b addr=%h", bus_a.o_data, bus_a.address_out, e.data, e.addr);
    end
    drop_b();
  endtask

  task automatic test_kernel_decode();
    res_t e, g;
    logic [4:0] codes [0:1];
    codes[0] = 5'b00000; codes[1] = 5'b11000;
    for (int i = 0; i < 10; i++) begin
      kernel_size = (i < 2) ? codes[i] : 5'($urandom);
      in_channel  = (i < 2) ? 12'd2 : 12'($urandom_range(120, 0));
      cmp_mode    = (i < 2) ? 1'b0 : 1'($urandom_range(1, 0));
      send(fill(1, 1), 12'(100 + i), 1'b1);
      send(rand_psum($urandom_range(3, 0)), 12'(200 + i), 1'b1);
      idle(LAT + 1);
    end
    idle(2);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL kernel_decode: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL kernel_decode: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL kernel_decode_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    drop_b();
  endtask

  task automatic test_random_groups();
    res_t e, g;
    int unsigned nb;
    for (int b = 0; b < 5; b++) begin
      kernel_size = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(4, 0));
      in_channel  = 12'($urandom_range(700, 0));
      cmp_mode    = 1'($urandom_range(1, 0));
      for (int g2 = 0; g2 < 6; g2++) begin
        nb = $urandom_range(4, 1);
        for (int t = 0; t < int'(nb); t++) begin
          send(rand_psum($urandom_range(31, 0)), 12'($urandom), t == int'(nb) - 1);
          if ($urandom_range(2, 0) == 0) idle($urandom_range(2, 1));
        end
      end
      idle(LAT + 2);
    end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL random_groups: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL random_groups: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL random_groups_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    drop_b();
  endtask

  task automatic test_reset_mid_group();
    res_t e, g;
    kernel_size = 5'b00001; in_channel = 12'd10; cmp_mode = 1'b1;
    send(fill(1, NL), 12'd7, 1'b0);
    idle(LAT + 2);
    send(fill(1, NL), 12'd8, 1'b0);
    idle(3);
    do_reset();
    send(fill(1, 5), 12'd9, 1'b1);
    idle(LAT + 3);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL reset_mid_group: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL reset_mid_group: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL reset_mid_group_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    drop_b();
  endtask

  task automatic test_saturation();
    res_t e, g;
    do_reset();
    kernel_size = 5'b10000; in_channel = 12'd620; cmp_mode = 1'b0;
    for (int i = 0; i < 3; i++) send(fill(31, NL), 12'(20 + i), i == 2);
    idle(2);
    send(fill(1, 1), 12'd30, 1'b1);
    idle(LAT + 3);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_checks++;
      if (got_b.size() == 0) begin n_fail++; $display("FAIL saturation_b: no result, required %p", e); end
      else begin g = got_b.pop_front(); if (g !== e) begin n_fail++; $display("FAIL saturation_b: got %p required %p", g, e); end end
    end
    n_checks++; if (got_b.size() != 0) begin n_fail++; $display("FAIL saturation_b_extra: got %0d extra results", got_b.size()); got_b.delete(); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_checks++;
      if (got_a.size() == 0) begin n_fail++; $display("FAIL saturation_a: no result, required %p", e); end
      else begin g = got_a.pop_front(); if (g !== e) begin n_fail++; $display("FAIL saturation_a: got %p required %p", g, e); end end
    end
    n_checks++; if (got_a.size() != 0) begin n_fail++; $display("FAIL saturation_a_extra: got %0d extra results", got_a.size()); got_a.delete(); end
    n_checks++; if (bus_b.o_ovf !== m_ovf_b) begin n_fail++; $display("FAIL ovf_sticky: got %b required %b", bus_b.o_ovf, m_ovf_b); end
    do_reset();
    n_checks++; if (bus_b.o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", bus_b.o_ovf); end
  endtask

  initial begin
    psum = '0; addr = '0; valid = 1'b0; last = 1'b0;
    in_channel = '0; kernel_size = 5'b00001; cmp_mode = 1'b0;
    m_acc_a = 0; m_acc_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    test_reset();
    test_single_beat();
    test_two_beat();
    test_back_to_back();
    test_kernel_decode();
    test_random_groups();
    test_reset_mid_group();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
